sprite_line_scheduler: RTL
==========================

Name: sprite_line_scheduler

Overview:
Per-scanline controller that walks the sprite attribute table and sequences sprite_drawer once per sprite hitting the requested line. It sits between the VGA timing logic, the attribute RAM and sprite_drawer, and owns the drawer's start/done handshake. Lower table index is drawn first, so higher-index sprites overwrite earlier ones in the line buffer.

Parameters:
NUM_SPRITES, 32, attribute table entries scanned per line (power of two, 2..256)
MAX_PER_LINE, 8, sprites drawn per line before the scan stops with overflow
SPRITE_H, 16, sprite height in rows (fixed at 16 to match the drawer row_off width)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
line_start  in  1  one-cycle pulse: begin scheduling line line_y
line_y  in  10  target scanline, sampled on line_start
attr_addr  out  $clog2(NUM_SPRITES)  attribute RAM read address
attr_q  in  32  attribute word, valid 1 cycle after attr_addr: [31] en, [30] flip, [29:20] x, [19:10] y, [9:8] rsvd, [7:0] frame_id
drw_start  out  1  one-cycle start pulse to sprite_drawer
drw_col_base  out  10  sprite x to drawer
drw_flip  out  1  horizontal flip to drawer
drw_frame_id  out  8  frame index to drawer
drw_row_off  out  4  row within sprite to drawer
drw_done  in  1  drawer idle/finished flag (high when idle)
busy  out  1  high from the cycle after line_start until line_done
line_done  out  1  one-cycle pulse when the line's scan completes
overflow  out  1  high if the last line hit more than MAX_PER_LINE sprites; cleared on next line_start

Behaviour:
- Reset (async): state IDLE; all outputs 0; internal index and hit count 0.
- States: IDLE, FETCH, EVAL, START, WAIT, FIN.
- IDLE: line_start -> latch line_y, idx=0, count=0, overflow=0, go FETCH.
- FETCH: drive attr_addr=idx; go EVAL next cycle (RAM latency 1).
- EVAL: diff = line_y - attr_q.y (10-bit unsigned). hit = en & (line_y >= y) & (diff[9:4]==0). No wrap: y > line_y is never a hit.
  - hit and count==MAX_PER_LINE: overflow<=1, go FIN.
  - hit: register col_base=x, flip, frame_id, row_off=diff[3:0]; go START.
  - miss: idx==NUM_SPRITES-1 -> FIN, else idx+1 -> FETCH.
- START: drw_start=1 for exactly one cycle, count+1; go WAIT. drw_done ignored this cycle.
- WAIT: drw_done==1 -> idx==NUM_SPRITES-1 ? FIN : (idx+1, FETCH). The drawer drops done on the edge that samples start, so the first WAIT cycle sees done=0.
- FIN: line_done=1 for one cycle, busy=0 next cycle, go IDLE.
- drw_col_base/flip/frame_id/row_off hold stable from START until leaving WAIT. The drawer reads col_base and flip throughout its run.
- Cost: a miss takes 2 cycles; a hit takes 3 + drawer time (about 18 cycles).
- line_start while busy aborts the current line: restart at idx 0, count 0. No line_done for the aborted line. If a drawer run is in flight, the next drw_start restarts the drawer, because start has priority in the drawer.
- line_start in FIN: the line_done pulse still fires, and the new line starts next cycle.
- Reset mid-line: immediate return to IDLE, drw_start=0. The drawer is reset by the same reset.

Decomposition:
- Package sprite_pkg:
  - sprite_attr_t packed struct (en, flip, x, y, rsvd, frame_id).
  - Field widths, plus SPRITE_H and SPRITE_W=16.
  - sched_state_t enum.
- Sub-module sprite_hit_check: combinational attr + line_y -> hit, row_off. It is reused later by the collision logic.

Test Plan:
1. Single sprite: idx 3 = {en=1, flip=0, x=100, y=50, frame=7}, line_y=55 -> one drw_start with col_base=100, row_off=5, frame_id=7; line_done after drw_done; overflow=0.
2. Boundaries: y=50, line_y=49 and line_y=66 -> no start. line_y=50 -> row_off 0; line_y=65 -> row_off 15. y=1000, line_y=5 -> no hit (no wrap).
3. Disabled and flip: en=0 at a matching y -> skipped. flip=1 entry -> drw_flip=1, held stable until done. All 32 entries missing -> line_done 2*32+1 cycles after line_start.
4. Overflow: 10 entries hit line 20 -> exactly 8 drw_start pulses, in ascending index order (0..7 hitting); overflow=1; line_done; overflow cleared on next line_start.
5. Handshake: drawer model holds drw_done low for 17 cycles -> no new FETCH until done rises. drw_start is never asserted twice without an intervening done.
6. Abort and reset: line_start mid-WAIT -> restart from idx 0, no line_done for the old line. Async reset mid-START -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite pipeline.
//   sprite_attr_t : one 32-bit attribute table word
//   sched_state_t : states of the per-line scheduler
//   SPRITE_H/W    : sprite dimensions in pixels
package sprite_pkg;

    localparam int COORD_W  = 10;
    localparam int FRAME_W  = 8;
    localparam int ROW_W    = 4;
    localparam int ATTR_W   = 32;
    localparam int SPRITE_H = 16;
    localparam int SPRITE_W = 16;

    // Bit layout: [31] en, [30] flip, [29:20] x, [19:10] y, [9:8] rsvd, [7:0] frame_id
    typedef struct packed {
        logic               en;
        logic               flip;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [1:0]         rsvd;
        logic [FRAME_W-1:0] frame_id;
    } sprite_attr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EVAL,
        ST_START,
        ST_WAIT,
        ST_FIN
    } sched_state_t;

endpackage

// File: rtl/sprite_hit_check.sv
// Combinational vertical hit test of one sprite against one scanline.
//   attr    : attribute word of the sprite
//   line_y  : scanline being tested
//   hit     : sprite enabled and covers line_y
//   row_off : row inside the sprite that line_y falls on
module sprite_hit_check
    import sprite_pkg::*;
#(
    parameter int HEIGHT = SPRITE_H
) (
    input  sprite_attr_t       attr,
    input  logic [COORD_W-1:0] line_y,
    output logic               hit,
    output logic [ROW_W-1:0]   row_off
);

    localparam int RW = $clog2(HEIGHT);

    logic [COORD_W-1:0] diff;

    // The explicit line_y >= y term stops a sprite near the bottom of the
    // coordinate space from wrapping round to hit lines near the top.
    assign diff    = line_y - attr.y;
    assign hit     = attr.en && (line_y >= attr.y) && (diff[COORD_W-1:RW] == '0);
    assign row_off = diff[ROW_W-1:0];

    // Horizontal and frame fields are not part of the vertical test.
    logic unused_fields;
    assign unused_fields = ^{attr.flip, attr.x, attr.rsvd, attr.frame_id};

endmodule

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler: walks the attribute table in index order and
// launches sprite_drawer once for every sprite covering the requested line.
//   clk, reset        : clock, asynchronous active-high reset
//   line_start/line_y : start scheduling line line_y (aborts a line in progress)
//   attr_addr/attr_q  : attribute RAM read port, one cycle latency
//   drw_*             : sprite_drawer command and start/done handshake
//   busy              : line in progress (includes the line_done cycle)
//   line_done         : one-cycle pulse at the end of a line's scan
//   overflow          : last line had more than MAX_PER_LINE hits
module sprite_line_scheduler #(
    parameter int NUM_SPRITES  = 32,
    parameter int MAX_PER_LINE = 8,
    parameter int SPRITE_H     = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           line_start,
    input  logic [9:0]                     line_y,
    output logic [$clog2(NUM_SPRITES)-1:0] attr_addr,
    input  logic [31:0]                    attr_q,
    output logic                           drw_start,
    output logic [9:0]                     drw_col_base,
    output logic                           drw_flip,
    output logic [7:0]                     drw_frame_id,
    output logic [3:0]                     drw_row_off,
    input  logic                           drw_done,
    output logic                           busy,
    output logic                           line_done,
    output logic                           overflow
);

    import sprite_pkg::*;

    localparam int IDX_W = $clog2(NUM_SPRITES);
    localparam int CNT_W = $clog2(MAX_PER_LINE + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_PER_LINE);

    sched_state_t       state_reg;
    sched_state_t       state_next;
    logic [IDX_W-1:0]   idx_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [COORD_W-1:0] line_y_reg;
    logic               overflow_reg;
    logic [COORD_W-1:0] col_base_reg;
    logic               flip_reg;
    logic [FRAME_W-1:0] frame_id_reg;
    logic [ROW_W-1:0]   row_off_reg;

    sprite_attr_t       attr;
    logic               hit;
    logic [ROW_W-1:0]   hit_row_off;
    logic               last_idx;
    logic               at_limit;

    assign attr     = attr_q;
    assign last_idx = (idx_reg == LAST_IDX);
    assign at_limit = (count_reg == CNT_MAX);

    sprite_hit_check #(
        .HEIGHT (SPRITE_H)
    ) u_hit_check (
        .attr    (attr),
        .line_y  (line_y_reg),
        .hit     (hit),
        .row_off (hit_row_off)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. line_start wins in every state, which gives both the
    // abort-and-restart behaviour and the FIN-to-new-line hand-off.
    always_comb begin
        state_next = state_reg;
        if (line_start) begin
            state_next = ST_FETCH;
        end else begin
            case (state_reg)
                ST_IDLE:  state_next = ST_IDLE;
                ST_FETCH: state_next = ST_EVAL;
                ST_EVAL: begin
                    if (hit) begin
                        state_next = at_limit ? ST_FIN : ST_START;
                    end else begin
                        state_next = last_idx ? ST_FIN : ST_FETCH;
                    end
                end
                ST_START: state_next = ST_WAIT;
                ST_WAIT: begin
                    // The drawer lowers done on the edge that samples start,
                    // so the first WAIT cycle cannot see a stale done.
                    if (drw_done) begin
                        state_next = last_idx ? ST_FIN : ST_FETCH;
                    end
                end
                ST_FIN:   state_next = ST_IDLE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    // Scan position, hit count, overflow and the command latched for the drawer.
    // The command registers only change in EVAL on a hit, so they stay put for
    // the whole START/WAIT span while the drawer is reading them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_reg      <= '0;
            count_reg    <= '0;
            line_y_reg   <= '0;
            overflow_reg <= 1'b0;
            col_base_reg <= '0;
            flip_reg     <= 1'b0;
            frame_id_reg <= '0;
            row_off_reg  <= '0;
        end else if (line_start) begin
            line_y_reg   <= line_y;
            idx_reg      <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_EVAL: begin
                    if (hit) begin
                        if (at_limit) begin
                            overflow_reg <= 1'b1;
                        end else begin
                            col_base_reg <= attr.x;
                            flip_reg     <= attr.flip;
                            frame_id_reg <= attr.frame_id;
                            row_off_reg  <= hit_row_off;
                        end
                    end else if (!last_idx) begin
                        idx_reg <= idx_reg + IDX_W'(1);
                    end
                end
                ST_START: begin
                    count_reg <= count_reg + CNT_W'(1);
                end
                ST_WAIT: begin
                    if (drw_done && !last_idx) begin
                        idx_reg <= idx_reg + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Output logic
    always_comb begin
        drw_start = (state_reg == ST_START);
        line_done = (state_reg == ST_FIN);
        busy      = (state_reg != ST_IDLE);
    end

    assign attr_addr    = idx_reg;
    assign overflow     = overflow_reg;
    assign drw_col_base = col_base_reg;
    assign drw_flip     = flip_reg;
    assign drw_frame_id = frame_id_reg;
    assign drw_row_off  = row_off_reg;

endmodule
